// File: rtl/pc_gen_ras_if.sv
// Fetch-side bundle between the pipeline and the PC generator with return-address stack.
// The PC[31] status output is named super_mode because `super` is a reserved SystemVerilog keyword.
interface pc_gen_ras_if;
    logic        Stall;
    logic [2:0]  ID_PCsrc;
    logic [2:0]  EX_PCsrc;
    logic        ALUOut0;
    logic [31:0] ConBA;
    logic [25:0] JTaddr;
    logic [31:0] DatabusA;
    logic        RAS_push;
    logic [31:0] RAS_pushAddr;
    logic        EX_JRCheck;
    logic [31:0] EX_JRTarget;
    logic [31:0] EX_JRPred;
    logic [31:0] PC;
    logic [31:0] PCplus4;
    logic        super_mode;
    logic [31:0] RAS_top;
    logic        RAS_empty;
    logic        RAS_full;
    logic        Mispredict;

    modport master (
        output Stall, ID_PCsrc, EX_PCsrc, ALUOut0, ConBA, JTaddr, DatabusA,
               RAS_push, RAS_pushAddr, EX_JRCheck, EX_JRTarget, EX_JRPred,
        input  PC, PCplus4, super_mode, RAS_top, RAS_empty, RAS_full, Mispredict
    );

    modport slave (
        input  Stall, ID_PCsrc, EX_PCsrc, ALUOut0, ConBA, JTaddr, DatabusA,
               RAS_push, RAS_pushAddr, EX_JRCheck, EX_JRTarget, EX_JRPred,
        output PC, PCplus4, super_mode, RAS_top, RAS_empty, RAS_full, Mispredict
    );
endinterface

// File: rtl/pc_gen_ras.sv
// Program counter generator with a circular return-address stack for JR prediction.
// EX-stage redirects (taken branch, JR mispredict) take priority and squash ID-stage stack effects.
module pc_gen_ras #(
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_VEC = 32'h80000000,
    parameter logic [31:0] INT_VEC   = 32'h80000004,
    parameter logic [31:0] EXC_VEC   = 32'h80000008
) (
    input  logic        CLK,
    input  logic        Reset_n,
    pc_gen_ras_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_DEPTH);

    logic [31:0]   pc_reg, pc_next, pc_plus4, ras_top;
    logic [PW-1:0] ptr_reg, ptr_next, wr_idx;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   ras_mem [RAS_DEPTH];
    logic          branch_taken, mispredict, ex_redirect;
    logic          do_push, do_pop, wr_en, ras_empty;

    // Bit 31 is the privilege bit and never carries out of the increment.
    assign pc_plus4     = {pc_reg[31], pc_reg[30:0] + 31'd4};
    assign ras_empty    = (count_reg == '0);
    assign ras_top      = ras_empty ? 32'd0 : ras_mem[ptr_reg];
    assign branch_taken = (bus.EX_PCsrc == 3'd1) && bus.ALUOut0;
    assign mispredict   = bus.EX_JRCheck && (bus.EX_JRTarget != bus.EX_JRPred) && !branch_taken;
    assign ex_redirect  = branch_taken || mispredict;
    assign do_push      = !bus.Stall && !ex_redirect && bus.RAS_push;
    assign do_pop       = !bus.Stall && !ex_redirect && (bus.ID_PCsrc == 3'd6) && !ras_empty;

    always_comb begin
        pc_next = pc_plus4;
        if (bus.Stall) begin
            pc_next = pc_reg;
        end else if (branch_taken) begin
            pc_next = bus.ConBA;
        end else if (mispredict) begin
            pc_next = bus.EX_JRTarget;
        end else begin
            case (bus.ID_PCsrc)
                3'd2:    pc_next = {pc_plus4[31:28], bus.JTaddr, 2'b00};
                3'd3:    pc_next = bus.DatabusA;
                3'd4:    pc_next = INT_VEC;
                3'd5:    pc_next = EXC_VEC;
                3'd6:    pc_next = ras_empty ? bus.DatabusA : ras_top;
                default: pc_next = pc_plus4;
            endcase
        end
    end

    // Push+pop in one cycle rewrites the top in place; a push when full wraps over the oldest entry.
    always_comb begin
        ptr_next   = ptr_reg;
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_idx     = ptr_reg;
        if (do_push && do_pop) begin
            wr_en = 1'b1;
        end else if (do_push) begin
            wr_en    = 1'b1;
            ptr_next = ptr_reg + PW'(1);
            wr_idx   = ptr_reg + PW'(1);
            if (count_reg != COUNT_FULL)
                count_next = count_reg + CW'(1);
        end else if (do_pop) begin
            ptr_next   = ptr_reg - PW'(1);
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_reg    <= RESET_VEC;
            ptr_reg   <= '0;
            count_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
            logic [31:0] entry_reg;
            always_ff @(posedge CLK or negedge Reset_n) begin
                if (!Reset_n)
                    entry_reg <= '0;
                else if (wr_en && (wr_idx == PW'(gi)))
                    entry_reg <= bus.RAS_pushAddr;
            end
            assign ras_mem[gi] = entry_reg;
        end
    endgenerate

    assign bus.PC         = pc_reg;
    assign bus.PCplus4    = pc_plus4;
    assign bus.super_mode = pc_reg[31];
    assign bus.RAS_top    = ras_top;
    assign bus.RAS_empty  = ras_empty;
    assign bus.RAS_full   = (count_reg == COUNT_FULL);
    assign bus.Mispredict = mispredict;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: queue-based stack model checked every cycle, plus directed literal checks.
module tb_pc_gen_ras;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV = 32'h80000000;
    localparam logic [31:0] IV = 32'h80000004;
    localparam logic [31:0] EV = 32'h80000008;

    logic CLK = 1'b0;
    logic Reset_n = 1'b0;
    always #5 CLK = ~CLK;

    pc_gen_ras_if bus();

    pc_gen_ras #(.RAS_DEPTH(DEPTH), .RESET_VEC(RV), .INT_VEC(IV), .EXC_VEC(EV)) dut (
        .CLK(CLK),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: PC value plus the stack as a queue whose back is the top.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic [31:0] m_npc;
    bit          m_taken, m_mis, m_pop;

    function automatic logic [31:0] p4(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction

    function automatic logic [31:0] m_top();
        return (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'd0;
    endfunction

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            m_pc = RV;
            m_q.delete();
        end else if (!bus.Stall) begin
            m_taken = (bus.EX_PCsrc == 3'd1) && bus.ALUOut0;
            m_mis   = bus.EX_JRCheck && (bus.EX_JRTarget != bus.EX_JRPred) && !m_taken;
            if (m_taken)                  m_npc = bus.ConBA;
            else if (m_mis)               m_npc = bus.EX_JRTarget;
            else if (bus.ID_PCsrc == 3'd2) m_npc = {p4(m_pc) & 32'hF0000000} | {4'd0, bus.JTaddr, 2'b00};
            else if (bus.ID_PCsrc == 3'd3) m_npc = bus.DatabusA;
            else if (bus.ID_PCsrc == 3'd4) m_npc = IV;
            else if (bus.ID_PCsrc == 3'd5) m_npc = EV;
            else if (bus.ID_PCsrc == 3'd6) m_npc = (m_q.size() > 0) ? m_top() : bus.DatabusA;
            else                           m_npc = p4(m_pc);
            if (!m_taken && !m_mis) begin
                m_pop = (bus.ID_PCsrc == 3'd6) && (m_q.size() > 0);
                if (bus.RAS_push && m_pop) begin
                    m_q[m_q.size()-1] = bus.RAS_pushAddr;
                end else if (bus.RAS_push) begin
                    m_q.push_back(bus.RAS_pushAddr);
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                end else if (m_pop) begin
                    void'(m_q.pop_back());
                end
            end
            m_pc = m_npc;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_pc", bus.PC, m_pc);
            chk("model_pcplus4", bus.PCplus4, p4(m_pc));
            chk("model_super", 32'(bus.super_mode), 32'(m_pc[31]));
            chk("model_ras_top", bus.RAS_top, m_top());
            chk("model_ras_empty", 32'(bus.RAS_empty), 32'(m_q.size() == 0));
            chk("model_ras_full", 32'(bus.RAS_full), 32'(m_q.size() == DEPTH));
            chk("model_mispredict", 32'(bus.Mispredict),
                32'(bus.EX_JRCheck && (bus.EX_JRTarget != bus.EX_JRPred)
                    && !((bus.EX_PCsrc == 3'd1) && bus.ALUOut0)));
        end
    end

    task automatic idle();
        bus.Stall = 1'b0;        bus.ID_PCsrc = 3'd0;    bus.EX_PCsrc = 3'd0;
        bus.ALUOut0 = 1'b0;      bus.ConBA = 32'd0;      bus.JTaddr = 26'd0;
        bus.DatabusA = 32'd0;    bus.RAS_push = 1'b0;    bus.RAS_pushAddr = 32'd0;
        bus.EX_JRCheck = 1'b0;   bus.EX_JRTarget = 32'd0; bus.EX_JRPred = 32'd0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] idle_tab [3] = '{32'h80000004, 32'h80000008, 32'h8000000C};
    logic [31:0] push_tab [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    logic [31:0] pop_tab  [4] = '{32'h5000, 32'h4000, 32'h3000, 32'h2000};

    initial begin
        idle();
        repeat (2) @(posedge CLK);
        chk_en = 1'b1;
        #1 Reset_n = 1'b1;
        chk("reset_pc", bus.PC, 32'h80000000);
        chk("reset_super", 32'(bus.super_mode), 32'd1);
        chk("reset_empty", 32'(bus.RAS_empty), 32'd1);
        chk("reset_full", 32'(bus.RAS_full), 32'd0);
        chk("reset_top", bus.RAS_top, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_pc", bus.PC, idle_tab[i]);
        end
        step();
        chk("idle_pc4", bus.PC, 32'h80000010);

        bus.ID_PCsrc = 3'd2; bus.JTaddr = 26'h0000040;
        step();
        chk("jump_pc", bus.PC, 32'h80000100);
        bus.EX_PCsrc = 3'd1; bus.ALUOut0 = 1'b1; bus.ConBA = 32'h80000200;
        step();
        chk("branch_over_jump", bus.PC, 32'h80000200);
        idle();

        for (int i = 0; i < 5; i++) begin
            bus.RAS_push = 1'b1; bus.RAS_pushAddr = push_tab[i];
            step();
        end
        idle();
        chk("push5_full", 32'(bus.RAS_full), 32'd1);
        chk("push5_top", bus.RAS_top, 32'h5000);
        for (int i = 0; i < 4; i++) begin
            bus.ID_PCsrc = 3'd6;
            step();
            chk("pop_pc", bus.PC, pop_tab[i]);
        end
        idle();
        chk("pop4_empty", 32'(bus.RAS_empty), 32'd1);
        chk("pop4_top", bus.RAS_top, 32'd0);
        bus.ID_PCsrc = 3'd6; bus.DatabusA = 32'h0000ABC0;
        step();
        chk("pop_empty_pc", bus.PC, 32'h0000ABC0);
        chk("pop_empty_still", 32'(bus.RAS_empty), 32'd1);
        idle();

        bus.RAS_push = 1'b1; bus.RAS_pushAddr = 32'h7000;
        step();
        chk("push7000_top", bus.RAS_top, 32'h7000);
        bus.RAS_pushAddr = 32'h9000; bus.ID_PCsrc = 3'd6;
        step();
        chk("pushpop_pc", bus.PC, 32'h7000);
        chk("pushpop_top", bus.RAS_top, 32'h9000);
        chk("pushpop_nonempty", 32'(bus.RAS_empty), 32'd0);
        idle();

        bus.RAS_push = 1'b1; bus.RAS_pushAddr = 32'hDEAD0;
        bus.EX_JRCheck = 1'b1; bus.EX_JRPred = 32'h1234; bus.EX_JRTarget = 32'h5678;
        #1 chk("mispredict_comb", 32'(bus.Mispredict), 32'd1);
        step();
        chk("mispredict_pc", bus.PC, 32'h5678);
        chk("mispredict_nopush", bus.RAS_top, 32'h9000);
        bus.RAS_push = 1'b0; bus.EX_PCsrc = 3'd1; bus.ALUOut0 = 1'b1;
        #1 chk("mispredict_masked", 32'(bus.Mispredict), 32'd0);
        idle();

        bus.ID_PCsrc = 3'd3; bus.DatabusA = 32'h7FFFFFFC;
        step();
        chk("wrap_pcplus4_user", bus.PCplus4, 32'h00000000);
        chk("wrap_super_user", 32'(bus.super_mode), 32'd0);
        bus.DatabusA = 32'hFFFFFFFC;
        step();
        chk("wrap_pcplus4_super", bus.PCplus4, 32'h80000000);

        bus.Stall = 1'b1; bus.ID_PCsrc = 3'd6; bus.RAS_push = 1'b1; bus.RAS_pushAddr = 32'hBEEF0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", bus.PC, 32'hFFFFFFFC);
            chk("stall_top", bus.RAS_top, 32'h9000);
        end
        Reset_n = 1'b0;
        #1;
        chk("async_reset_pc", bus.PC, 32'h80000000);
        chk("async_reset_top", bus.RAS_top, 32'd0);
        chk("async_reset_empty", 32'(bus.RAS_empty), 32'd1);
        step();
        idle();
        Reset_n = 1'b1;
        step();
        chk("post_reset_pc", bus.PC, 32'h80000004);

        for (int n = 0; n < 600; n++) begin
            bus.Stall        = ($urandom_range(0, 4) == 0);
            bus.ID_PCsrc     = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
            bus.EX_PCsrc     = ($urandom_range(0, 4) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            bus.ALUOut0      = 1'($urandom_range(0, 1));
            bus.ConBA        = $urandom;
            bus.JTaddr       = 26'($urandom);
            bus.DatabusA     = $urandom;
            bus.RAS_push     = ($urandom_range(0, 2) == 0);
            bus.RAS_pushAddr = $urandom;
            bus.EX_JRCheck   = ($urandom_range(0, 3) == 0);
            bus.EX_JRPred    = $urandom;
            bus.EX_JRTarget  = ($urandom_range(0, 1) == 1) ? bus.EX_JRPred : $urandom;
            Reset_n          = ($urandom_range(0, 99) != 0);
            step();
        end
        Reset_n = 1'b1;
        idle();
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_gen_ras.md
PC_GEN_RAS -- requirements
Module: pc_gen_ras

Interface
REQ-001 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, 2..16.
REQ-002 Parameter RESET_VEC, default 32'h80000000, PC value after reset.
REQ-003 Parameter INT_VEC, default 32'h80000004, interrupt entry address.
REQ-004 Parameter EXC_VEC, default 32'h80000008, exception entry address.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 Reset_n  input  1  reset, asynchronous, active-low.
REQ-007 Stall  input  1  hold PC and RAS when 1.
REQ-008 ID_PCsrc  input  3  ID-stage select: 2 J, 3 JR via DatabusA, 4 interrupt, 5 exception, 6 JR via RAS, others sequential.
REQ-009 EX_PCsrc  input  3  EX-stage select; 1 = conditional branch.
REQ-010 ALUOut0  input  1  branch condition true.
REQ-011 ConBA  input  32  branch target.
REQ-012 JTaddr  input  26  jump index.
REQ-013 DatabusA  input  32  register JR target.
REQ-014 RAS_push  input  1  ID holds JAL/JALR.
REQ-015 RAS_pushAddr  input  32  return address to push.
REQ-016 EX_JRCheck  input  1  EX holds a RAS-predicted JR.
REQ-017 EX_JRTarget  input  32  resolved JR target.
REQ-018 EX_JRPred  input  32  target predicted for that JR.
REQ-019 PC  output  32  current fetch address, registered.
REQ-020 PCplus4  output  32  {PC[31], (PC+4)[30:0]}.
REQ-021 super  output  1  PC[31].
REQ-022 RAS_top  output  32  top entry; 0 when empty.
REQ-023 RAS_empty / RAS_full  output  1 each  occupancy == 0 / == RAS_DEPTH.
REQ-024 Mispredict  output  1  combinational: EX_JRCheck & (EX_JRTarget != EX_JRPred) & !(EX_PCsrc==1 & ALUOut0).

Function
REQ-025 Stall=1: PC, RAS entries, pointer, count unchanged; outputs reflect held state.
REQ-026 Stall=0: next PC by priority: (a) EX_PCsrc==1 & ALUOut0 -> ConBA; (b) Mispredict -> EX_JRTarget; (c) ID_PCsrc 2 -> {PCplus4[31:28], JTaddr, 2'b00}; (d) 3 -> DatabusA; (e) 4 -> INT_VEC; (f) 5 -> EXC_VEC; (g) 6 -> RAS_top, or DatabusA if RAS_empty; (h) else PCplus4.
REQ-027 Latency: one cycle from select to PC; no bubbles inserted by this block.
REQ-028 PCplus4 never changes bit 31; 32'h7FFFFFFC -> 32'h7FFFFFFC+4 wraps bits 30:0 to 0 with bit31=0 kept.
REQ-029 EX redirect (a or b) squashes ID-stage effects that cycle: no push, no pop.
REQ-030 Push (RAS_push, Stall=0, no EX redirect): write RAS_pushAddr at ptr+1 (mod RAS_DEPTH), ptr advances, count = min(count+1, RAS_DEPTH).
REQ-031 Push when full: oldest entry silently overwritten (circular), count stays RAS_DEPTH.
REQ-032 Pop (ID_PCsrc==6, Stall=0, no EX redirect, count>0): ptr retreats mod RAS_DEPTH, count-1.
REQ-033 Pop when empty: no state change; PC takes DatabusA.
REQ-034 Push and pop same cycle: top entry replaced by RAS_pushAddr, ptr and count unchanged; PC still takes old RAS_top.
REQ-035 ID_PCsrc 4/5 do not modify RAS.
REQ-036 Pointer width clog2(RAS_DEPTH); count width clog2(RAS_DEPTH)+1; no other arithmetic overflow permitted.

Reset
REQ-037 Reset_n=0 asynchronously: PC=RESET_VEC, ptr=0, count=0, all entries 0; RAS_empty=1, RAS_full=0, RAS_top=0.
REQ-038 Reset mid-push/pop discards the operation; first post-reset edge with Stall=0, select 0 gives PC=RESET_VEC+4.

Verification
REQ-039 Reset, 3 idle cycles -> PC 80000000, 80000004, 80000008, 8000000C; super=1.
REQ-040 ID_PCsrc=2, JTaddr=26'h0000040, PC=80000010 -> next PC 80000100; same cycle EX_PCsrc=1, ALUOut0=1, ConBA=80000200 -> PC 80000200 instead.
REQ-041 RAS_DEPTH=4: push 1000,2000,3000,4000,5000 -> RAS_full=1, RAS_top=5000; four pops -> PC 5000,4000,3000,2000; fifth-pop count 0 -> RAS_empty=1, next pop uses DatabusA.
REQ-042 Push 9000 with pop, top=7000 -> PC 7000, RAS_top 9000, count unchanged.
REQ-043 EX_JRCheck=1, EX_JRPred=1234, EX_JRTarget=5678, simultaneous RAS_push -> Mispredict=1, PC 5678, count unchanged.
REQ-044 Stall=1 for 3 cycles with ID_PCsrc=6 and RAS_push=1 -> PC, count, RAS_top constant; Reset_n low mid-cycle -> PC 80000000 immediately.
